// File: rtl/i2c_cfg_launcher_pkg.sv
// Shared types and width helper for the I2C configuration launcher.
package i2c_cfg_launcher_pkg;

  typedef enum logic [2:0] {
    StPwrup,
    StIdle,
    StResetSub,
    StSettle,
    StStart,
    StWaitDone,
    StOk,
    StFail
  } launcher_state_t;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int unsigned cl2(input int unsigned n);
    return (n <= 32'd1) ? 32'd1 : unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/i2c_cfg_launcher_btn_debounce.sv
// Push-button conditioning: 2-FF synchroniser, stability counter and a one-cycle
// pulse on the accepted level's rising edge.
module i2c_cfg_launcher_btn_debounce
  import i2c_cfg_launcher_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int unsigned CntW = cl2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            lvl_q, lvl_prev_q;
  logic [CntW-1:0] cnt_q;

  // Bring the raw button into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

  // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lvl_q      <= 1'b0;
      lvl_prev_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      lvl_prev_q <= lvl_q;
      if (sync2_q == lvl_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntLast) begin
        lvl_q <= sync2_q;
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // Both operands are flops, so this stays free of input-to-output paths.
  assign press_o = lvl_q & ~lvl_prev_q;

endmodule

// File: rtl/i2c_cfg_launcher.sv
// Launch controller for the I2C/UART configuration subsystem: power-up reset hold,
// start pulse (auto or button), done watchdog with bounded retries, status outputs.
module i2c_cfg_launcher
  import i2c_cfg_launcher_pkg::*;
#(
  parameter int unsigned PWRUP_CYCLES    = 1000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 50000000,
  parameter int unsigned RST_CYCLES      = 16,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned AUTO_START      = 1
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              btn_i,
  input  logic                              cfg_done_i,
  output logic                              start_1cc_o,
  output logic                              sub_rst_n_o,
  output logic                              busy_o,
  output logic                              ok_o,
  output logic                              fail_o,
  output logic [cl2(MAX_RETRIES + 1)-1:0]   retry_cnt_o
);

  localparam int unsigned PwrW   = cl2(PWRUP_CYCLES + 1);
  localparam int unsigned ToW    = cl2(TIMEOUT_CYCLES + 1);
  localparam int unsigned RstW   = cl2(RST_CYCLES + 1);
  localparam int unsigned RetryW = cl2(MAX_RETRIES + 1);

  localparam logic [PwrW-1:0]   PwrLast  = PwrW'(PWRUP_CYCLES - 1);
  localparam logic [ToW-1:0]    ToLast   = ToW'(TIMEOUT_CYCLES - 1);
  localparam logic [RstW-1:0]   RstLast  = RstW'(RST_CYCLES - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRIES);

  launcher_state_t   state_q;
  logic [PwrW-1:0]   pwr_cnt_q;
  logic [ToW-1:0]    to_cnt_q;
  logic [RstW-1:0]   rst_cnt_q;
  logic [RetryW-1:0] retry_q;
  logic              start_q, sub_rst_n_q, busy_q, ok_q, fail_q;
  logic              btn_press;

  i2c_cfg_launcher_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .btn_i   (btn_i),
    .press_o (btn_press)
  );

  // Sequencer; every output is set on the transition into the state that owns it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StPwrup;
      pwr_cnt_q   <= '0;
      to_cnt_q    <= '0;
      rst_cnt_q   <= '0;
      retry_q     <= '0;
      start_q     <= 1'b0;
      sub_rst_n_q <= 1'b0;
      busy_q      <= 1'b1;
      ok_q        <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        StPwrup: begin
          if (pwr_cnt_q == PwrLast) begin
            pwr_cnt_q <= '0;
            if (AUTO_START != 0) begin
              state_q <= StResetSub;
            end else begin
              state_q     <= StIdle;
              sub_rst_n_q <= 1'b1;
              busy_q      <= 1'b0;
            end
          end else begin
            pwr_cnt_q <= pwr_cnt_q + 1'b1;
          end
        end
        StIdle, StOk, StFail: begin
          if (btn_press) begin
            state_q     <= StResetSub;
            sub_rst_n_q <= 1'b0;
            busy_q      <= 1'b1;
            ok_q        <= 1'b0;
            fail_q      <= 1'b0;
            retry_q     <= '0;
            rst_cnt_q   <= '0;
          end
        end
        StResetSub: begin
          if (rst_cnt_q == RstLast) begin
            rst_cnt_q   <= '0;
            sub_rst_n_q <= 1'b1;
            state_q     <= StSettle;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        StSettle: begin
          state_q  <= StStart;
          start_q  <= 1'b1;
          to_cnt_q <= '0;
        end
        StStart: begin
          state_q <= StWaitDone;
        end
        StWaitDone: begin
          // Done wins over a simultaneous timeout.
          if (cfg_done_i) begin
            state_q  <= StOk;
            ok_q     <= 1'b1;
            busy_q   <= 1'b0;
            to_cnt_q <= '0;
          end else if (to_cnt_q == ToLast) begin
            to_cnt_q <= '0;
            if (retry_q < RetryMax) begin
              retry_q     <= retry_q + 1'b1;
              sub_rst_n_q <= 1'b0;
              rst_cnt_q   <= '0;
              state_q     <= StResetSub;
            end else begin
              fail_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= StFail;
            end
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= StPwrup;
        end
      endcase
    end
  end

  assign start_1cc_o = start_q;
  assign sub_rst_n_o = sub_rst_n_q;
  assign busy_o      = busy_q;
  assign ok_o        = ok_q;
  assign fail_o      = fail_q;
  assign retry_cnt_o = retry_q;

endmodule

// File: tb/tb_i2c_cfg_launcher.sv
// Directed bench for i2c_cfg_launcher: one auto-start instance and one button instance.
module tb_i2c_cfg_launcher;

  localparam int unsigned Pwrup   = 8;
  localparam int unsigned Deb     = 4;
  localparam int unsigned Tmo     = 20;
  localparam int unsigned RstC    = 3;
  localparam int unsigned MaxRetr = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       btn_a = 1'b0;
  logic       cfg_done_a = 1'b0;
  logic       start_a, subrst_a, busy_a, ok_a, fail_a;
  logic [1:0] retry_a;

  logic       btn_b = 1'b0;
  logic       cfg_done_b = 1'b0;
  logic       start_b, subrst_b, busy_b, ok_b, fail_b;
  logic [1:0] retry_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  i2c_cfg_launcher #(
    .PWRUP_CYCLES    (Pwrup),
    .DEBOUNCE_CYCLES (Deb),
    .TIMEOUT_CYCLES  (Tmo),
    .RST_CYCLES      (RstC),
    .MAX_RETRIES     (MaxRetr),
    .AUTO_START      (1)
  ) u_dut_auto (
    .clk_i       (clk),
    .rst_i       (rst),
    .btn_i       (btn_a),
    .cfg_done_i  (cfg_done_a),
    .start_1cc_o (start_a),
    .sub_rst_n_o (subrst_a),
    .busy_o      (busy_a),
    .ok_o        (ok_a),
    .fail_o      (fail_a),
    .retry_cnt_o (retry_a)
  );

  i2c_cfg_launcher #(
    .PWRUP_CYCLES    (Pwrup),
    .DEBOUNCE_CYCLES (Deb),
    .TIMEOUT_CYCLES  (Tmo),
    .RST_CYCLES      (RstC),
    .MAX_RETRIES     (MaxRetr),
    .AUTO_START      (0)
  ) u_dut_btn (
    .clk_i       (clk),
    .rst_i       (rst),
    .btn_i       (btn_b),
    .cfg_done_i  (cfg_done_b),
    .start_1cc_o (start_b),
    .sub_rst_n_o (subrst_b),
    .busy_o      (busy_b),
    .ok_o        (ok_b),
    .fail_o      (fail_b),
    .retry_cnt_o (retry_b)
  );

  // Hold reset for two cycles and release it on a falling edge.
  task automatic apply_reset();
    rst        = 1'b1;
    cfg_done_a = 1'b0;
    cfg_done_b = 1'b0;
    btn_b      = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Returns at the falling edge where start_a is first seen high.
  task automatic wait_start_a(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound && !seen; i++) begin
      @(negedge clk);
      if (start_a) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({start_a, subrst_a, busy_a, ok_a, fail_a, retry_a} !== 7'b0010000) begin
      bad++;
      $display("FAIL reset_outputs: got start=%b subrst=%b busy=%b ok=%b fail=%b retry=%0d, want 0 0 1 0 0 0",
               start_a, subrst_a, busy_a, ok_a, fail_a, retry_a);
    end
    total++;
    if ({subrst_b, busy_b} !== 2'b01) begin
      bad++;
      $display("FAIL reset_btn_inst: got subrst=%b busy=%b, want 0 1", subrst_b, busy_b);
    end
  endtask

  task automatic test_auto_ok();
    int low;
    int starts;
    apply_reset();
    #1;
    low = 0;
    while (subrst_a == 1'b0 && low < 40) begin
      low++;
      @(negedge clk);
    end
    // Power-up hold runs straight into the first reset pulse.
    total++;
    if (low != Pwrup + RstC) begin
      bad++;
      $display("FAIL auto_low_run: got %0d cycles, want %0d", low, Pwrup + RstC);
    end
    @(negedge clk);
    total++;
    if (start_a !== 1'b1) begin
      bad++;
      $display("FAIL auto_start_after_settle: got start=%b, want 1", start_a);
    end
    starts = 1;
    repeat (5) begin
      @(negedge clk);
      if (start_a) starts++;
    end
    cfg_done_a = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (start_a) starts++;
    end
    total++;
    if (starts != 1) begin
      bad++;
      $display("FAIL auto_one_pulse: got %0d start cycles, want 1", starts);
    end
    total++;
    if ({ok_a, busy_a, fail_a, retry_a} !== 5'b10000) begin
      bad++;
      $display("FAIL auto_ok_status: got ok=%b busy=%b fail=%b retry=%0d, want 1 0 0 0",
               ok_a, busy_a, fail_a, retry_a);
    end
  endtask

  task automatic test_retries_fail();
    int times[8];
    int lows[8];
    int n;
    int cur_low;
    int last_low;
    apply_reset();
    n = 0;
    cur_low = 0;
    last_low = 0;
    for (int t = 0; t < 130; t++) begin
      @(negedge clk);
      if (!subrst_a) begin
        cur_low++;
      end else if (cur_low > 0) begin
        last_low = cur_low;
        cur_low = 0;
      end
      if (start_a && n < 8) begin
        times[n] = t;
        lows[n] = last_low;
        n++;
      end
    end
    total++;
    if (n != 3) begin
      bad++;
      $display("FAIL retry_pulse_count: got %0d, want 3", n);
    end
    if (n >= 3) begin
      for (int k = 1; k < 3; k++) begin
        total++;
        if (times[k] - times[k-1] != Tmo + RstC + 2) begin
          bad++;
          $display("FAIL retry_spacing_%0d: got %0d, want %0d", k, times[k] - times[k-1],
                   Tmo + RstC + 2);
        end
        total++;
        if (lows[k] != RstC) begin
          bad++;
          $display("FAIL retry_rst_low_%0d: got %0d, want %0d", k, lows[k], RstC);
        end
      end
    end
    total++;
    if ({fail_a, ok_a, busy_a, retry_a} !== 5'b10010) begin
      bad++;
      $display("FAIL retry_exhausted: got fail=%b ok=%b busy=%b retry=%0d, want 1 0 0 2",
               fail_a, ok_a, busy_a, retry_a);
    end
  endtask

  task automatic test_second_attempt_ok();
    bit seen;
    apply_reset();
    wait_start_a(40, seen);
    if (seen) wait_start_a(40, seen);
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL second_attempt_start: got no start within bound, want start");
    end
    repeat (5) @(negedge clk);
    cfg_done_a = 1'b1;
    repeat (5) @(negedge clk);
    total++;
    if ({ok_a, fail_a, busy_a, retry_a} !== 5'b10001) begin
      bad++;
      $display("FAIL second_attempt_ok: got ok=%b fail=%b busy=%b retry=%0d, want 1 0 0 1",
               ok_a, fail_a, busy_a, retry_a);
    end
  endtask

  task automatic test_timeout_boundary();
    bit seen;
    int starts;
    // Done arrives on the last allowed wait cycle: success, no retry.
    apply_reset();
    wait_start_a(40, seen);
    repeat (Tmo) @(negedge clk);
    cfg_done_a = 1'b1;
    starts = 0;
    repeat (30) begin
      @(negedge clk);
      if (start_a) starts++;
    end
    total++;
    if ({seen, ok_a, retry_a, starts[0]} !== 5'b11000) begin
      bad++;
      $display("FAIL timeout_same_cycle: got seen=%b ok=%b retry=%0d starts=%0d, want 1 1 0 0",
               seen, ok_a, retry_a, starts);
    end
    // One cycle later the timeout wins and the next attempt succeeds at once.
    apply_reset();
    wait_start_a(40, seen);
    repeat (Tmo + 1) @(negedge clk);
    cfg_done_a = 1'b1;
    repeat (15) @(negedge clk);
    total++;
    if ({seen, ok_a, retry_a} !== 4'b1101) begin
      bad++;
      $display("FAIL timeout_one_late: got seen=%b ok=%b retry=%0d, want 1 1 1",
               seen, ok_a, retry_a);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    int low;
    apply_reset();
    wait_start_a(40, seen);
    if (seen) wait_start_a(40, seen);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if ({seen, subrst_a, start_a, ok_a, fail_a, busy_a, retry_a} !== 8'b10000100) begin
      bad++;
      $display("FAIL reset_mid_wait: got seen=%b subrst=%b start=%b ok=%b fail=%b busy=%b retry=%0d, want 1 0 0 0 0 1 0",
               seen, subrst_a, start_a, ok_a, fail_a, busy_a, retry_a);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    low = 0;
    while (subrst_a == 1'b0 && low < 40) begin
      low++;
      @(negedge clk);
    end
    total++;
    if (low != Pwrup + RstC) begin
      bad++;
      $display("FAIL reset_mid_repowerup: got low run %0d, want %0d", low, Pwrup + RstC);
    end
  endtask

  task automatic test_button();
    int nb;
    int lat;
    apply_reset();
    repeat (Pwrup + 4) @(negedge clk);
    total++;
    if ({busy_b, subrst_b, start_b} !== 3'b010) begin
      bad++;
      $display("FAIL btn_idle: got busy=%b subrst=%b start=%b, want 0 1 0", busy_b, subrst_b,
               start_b);
    end
    nb = 0;
    for (int i = 0; i < 6; i++) begin
      btn_b = ~btn_b;
      repeat (2) begin
        @(negedge clk);
        if (start_b) nb++;
      end
    end
    btn_b = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (start_b) nb++;
    end
    btn_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (start_b) nb++;
    end
    btn_b = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (start_b) nb++;
    end
    total++;
    if (nb != 0 || busy_b !== 1'b0) begin
      bad++;
      $display("FAIL btn_glitch_ignored: got starts=%0d busy=%b, want 0 0", nb, busy_b);
    end
    // Stable 6-cycle press; lat counts rising edges from the press.
    btn_b = 1'b1;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 6) btn_b = 1'b0;
      if (start_b) break;
    end
    // The subsystem captures the pulse on the following rising edge.
    total++;
    if (lat + 1 != 2 + Deb + 1 + RstC + 1 + 1) begin
      bad++;
      $display("FAIL btn_latency: got %0d, want %0d", lat + 1, 2 + Deb + 1 + RstC + 1 + 1);
    end
    btn_b = 1'b0;
    nb = 0;
    repeat (4) @(negedge clk);
    btn_b = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (start_b) nb++;
    end
    btn_b = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (start_b) nb++;
    end
    total++;
    if (nb != 0 || busy_b !== 1'b1) begin
      bad++;
      $display("FAIL btn_press_in_wait: got starts=%0d busy=%b, want 0 1", nb, busy_b);
    end
    cfg_done_b = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({ok_b, busy_b, fail_b, retry_b} !== 5'b10000) begin
      bad++;
      $display("FAIL btn_ok_status: got ok=%b busy=%b fail=%b retry=%0d, want 1 0 0 0",
               ok_b, busy_b, fail_b, retry_b);
    end
  endtask

  initial begin
    test_reset();
    test_auto_ok();
    test_retries_fail();
    test_second_attempt_ok();
    test_button();
    test_timeout_boundary();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_cfg_launcher.md
Name: i2c_cfg_launcher

Overview:
- Control stage directly upstream of the I2C/UART configuration subsystem. Holds the subsystem in reset through power-up, then issues its start pulse, either automatically or from a debounced push-button.
- Watches the subsystem's done level with a timeout. On timeout it resets the subsystem and retries, up to a bounded count.
- Reports busy / ok / fail status to LEDs or to a top-level sequencer.

Parameters:
- PWRUP_CYCLES, 1000000, cycles the subsystem is held in reset after rst_i deasserts.
- DEBOUNCE_CYCLES, 500000, cycles the synchronised button must stay stable before its level is accepted.
- TIMEOUT_CYCLES, 50000000, WAIT_DONE cycles allowed per attempt.
- RST_CYCLES, 16, low-time of sub_rst_n_o per reset pulse (must be >= 1).
- MAX_RETRIES, 3, retries after the first attempt.
- AUTO_START, 1, 1 = launch one attempt automatically after power-up.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset.
- btn_i  in  1  raw asynchronous push-button, active-high.
- cfg_done_i  in  1  subsystem done level; held 1 once configuration completes.
- start_1cc_o  out  1  one-cycle start pulse to the subsystem.
- sub_rst_n_o  out  1  active-low synchronous reset to the subsystem.
- busy_o  out  1  sequence in progress.
- ok_o  out  1  last sequence succeeded.
- fail_o  out  1  last sequence exhausted all retries.
- retry_cnt_o  out  cl2(MAX_RETRIES+1)  retries consumed by the last or current sequence.

Behaviour:
- Clock and reset (decided): one clock; reset is asynchronous and active-high.
- Reset values: state PWRUP, all counters 0, start_1cc_o=0, sub_rst_n_o=0, busy_o=1, ok_o=0, fail_o=0, retry_cnt_o=0. All outputs are registered or decoded directly from state; no combinational path from any input to any output.
- busy_o = 1 in every state except IDLE, OK and FAIL.
- Button path:
  - 2-FF synchroniser, then debouncer. The accepted level updates only after DEBOUNCE_CYCLES consecutive equal samples; a shorter glitch is ignored.
  - btn_press is a one-cycle pulse on the accepted level's 0->1 edge.
- States:
  - PWRUP: sub_rst_n_o=0; counts PWRUP_CYCLES, then goes to RESET_SUB if AUTO_START=1, otherwise to IDLE.
  - IDLE / OK / FAIL: sub_rst_n_o=1. On btn_press: clear ok_o, fail_o and retry_cnt_o; go to RESET_SUB. btn_press in any other state is dropped, not queued.
  - RESET_SUB: sub_rst_n_o=0 for exactly RST_CYCLES cycles, then go to SETTLE.
  - SETTLE: sub_rst_n_o=1 for one cycle, so the subsystem is in its idle state before the start pulse; go to START.
  - START: start_1cc_o=1 for this single cycle; clear the timeout counter; go to WAIT_DONE.
  - WAIT_DONE:
    - cfg_done_i=1 -> OK with ok_o=1.
    - Otherwise, on the TIMEOUT_CYCLES-th cycle in this state: if retry_cnt_o < MAX_RETRIES, increment retry_cnt_o and go to RESET_SUB; else go to FAIL with fail_o=1.
    - cfg_done_i arriving in the same cycle as timeout expiry counts as success.
- cfg_done_i is ignored outside WAIT_DONE.
- Counter widths: cl2(PWRUP_CYCLES+1), cl2(DEBOUNCE_CYCLES+1), cl2(TIMEOUT_CYCLES+1), cl2(RST_CYCLES+1). No wrap-around: each counter is cleared on state entry.
- rst_i mid-sequence: immediate return to reset values; sub_rst_n_o=0 aborts the subsystem; any pending start pulse is lost.
- Latency, button to start (cycles): 2 (sync) + DEBOUNCE_CYCLES + 1 (edge) + RST_CYCLES + 1 (SETTLE) + 1 (START).

Decomposition:
- utils package: add launcher_state_t (PWRUP, IDLE, RESET_SUB, SETTLE, START, WAIT_DONE, OK, FAIL); reuse cl2 for all widths.
- One sub-module, btn_debounce (synchroniser + stability counter + rising-edge pulse), parameter DEBOUNCE_CYCLES.

Test Plan:
Bench parameters for all cases: PWRUP=8, DEBOUNCE=4, TIMEOUT=20, RST=3, MAX_RETRIES=2.
1. AUTO_START=1, release reset, raise cfg_done_i 5 cycles after start_1cc_o -> sub_rst_n_o low for 8 cycles, then 3; exactly one start pulse; ok_o=1, busy_o=0, retry_cnt_o=0.
2. cfg_done_i held 0 -> three start pulses spaced 20+3+1+1 cycles apart, each preceded by a 3-cycle sub_rst_n_o low; then fail_o=1, retry_cnt_o=2, no fourth pulse.
3. cfg_done_i raised during the second attempt -> ok_o=1, retry_cnt_o=1, fail_o=0.
4. AUTO_START=0: btn_i toggled every 2 cycles for 12 cycles, then a 3-cycle glitch -> no start. Then held high for 6 cycles -> exactly one start, 2+4+1+3+1+1 cycles after the stable edge. A second press during WAIT_DONE is ignored.
5. cfg_done_i rises exactly on the 20th WAIT_DONE cycle -> OK, retry_cnt_o unchanged.
6. rst_i asserted mid WAIT_DONE -> next observation: sub_rst_n_o=0, start_1cc_o=0, ok_o=fail_o=0, busy_o=1, state PWRUP.
